// File: rtl/alu_dispatch.sv
// alu_dispatch: command front-end for a bank of start/done ALU function units.
//
// Accepts {op, a, b} over a valid/ready handshake, pulses the selected
// unit's start for one cycle, waits for that unit's done, captures its
// 16-bit result with zero/neg flags and holds the response until the
// consumer takes it. Opcodes >= NUM_OPS never start a unit and return an
// error response (res=0, zero=1, err=1).
//
// Optional feature: define ALU_DISPATCH_TIMEOUT_EN to add a WAIT watchdog
// that returns an error response after TIMEOUT cycles without a done.
//
// Ports:
//   clk_i, rst_ni           clock (rising edge), async active-low reset
//   cmd_valid_i/cmd_ready_o command handshake
//   cmd_op_i, cmd_a_i/_b_i  opcode and operands
//   unit_a_o, unit_b_o      registered operands broadcast to all units
//   unit_start_o            one-hot, one-cycle start pulse
//   unit_done_i, unit_res_i per-unit done pulse and 16-bit result slice
//   rsp_valid_o/rsp_ready_i response handshake
//   rsp_res_o, rsp_zero_o, rsp_neg_o, rsp_err_o  response payload
module alu_dispatch #(
  parameter int NUM_OPS = 8,
  parameter int OP_W    = 3,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [OP_W-1:0]       cmd_op_i,
  input  logic [7:0]            cmd_a_i,
  input  logic [7:0]            cmd_b_i,
  output logic [7:0]            unit_a_o,
  output logic [7:0]            unit_b_o,
  output logic [NUM_OPS-1:0]    unit_start_o,
  input  logic [NUM_OPS-1:0]    unit_done_i,
  input  logic [16*NUM_OPS-1:0] unit_res_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [15:0]           rsp_res_o,
  output logic                  rsp_zero_o,
  output logic                  rsp_neg_o,
  output logic                  rsp_err_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [7:0]         a_q, a_d, b_q, b_d;
  logic [NUM_OPS-1:0] start_q, start_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;
  logic [15:0]        res_q, res_d;
  logic               zero_q, zero_d, neg_q, neg_d, err_q, err_d;

  logic [NUM_OPS-1:0] cmd_sel, op_sel;
  logic               done_sel;
  logic [15:0]        res_sel;

`ifdef ALU_DISPATCH_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  // Count value seen during the last permitted WAIT cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // Opcode decode; an out-of-range opcode decodes to all zeros, which both
  // suppresses the start pulse and marks the command illegal.
  always_comb begin
    cmd_sel  = '0;
    op_sel   = '0;
    done_sel = 1'b0;
    res_sel  = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      cmd_sel[i] = (cmd_op_i == OP_W'(i));
      op_sel[i]  = (op_q == OP_W'(i));
      if (op_q == OP_W'(i)) begin
        done_sel = done_sel | unit_done_i[i];
        res_sel  = res_sel | unit_res_i[16*i +: 16];
      end
    end
  end

  // Illegal opcodes still pass through ISSUE (with no start) so their error
  // response appears one cycle after acceptance.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    start_d = '0;
    ready_d = ready_q;
    valid_d = valid_q;
    res_d   = res_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    err_d   = err_q;
`ifdef ALU_DISPATCH_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && ready_q) begin
          op_d    = cmd_op_i;
          a_d     = cmd_a_i;
          b_d     = cmd_b_i;
          start_d = cmd_sel;
          ready_d = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (|op_sel) begin
          state_d = S_WAIT;
`ifdef ALU_DISPATCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = S_HOLD;
          valid_d = 1'b1;
          res_d   = '0;
          zero_d  = 1'b1;
          neg_d   = 1'b0;
          err_d   = 1'b1;
        end
      end
      S_WAIT: begin
        // A done in the same cycle as the watchdog limit takes priority.
        if (done_sel) begin
          state_d = S_HOLD;
          valid_d = 1'b1;
          res_d   = res_sel;
          zero_d  = (res_sel == 16'h0000);
          neg_d   = res_sel[15];
          err_d   = 1'b0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HOLD;
          valid_d = 1'b1;
          res_d   = '0;
          zero_d  = 1'b1;
          neg_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      S_HOLD: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      start_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      start_q <= start_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
`ifdef ALU_DISPATCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign cmd_ready_o  = ready_q;
  assign unit_a_o     = a_q;
  assign unit_b_o     = b_q;
  assign unit_start_o = start_q;
  assign rsp_valid_o  = valid_q;
  assign rsp_res_o    = res_q;
  assign rsp_zero_o   = zero_q;
  assign rsp_neg_o    = neg_q;
  assign rsp_err_o    = err_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: self-checking bench for alu_dispatch (NUM_OPS=6, so
// opcodes 6 and 7 are illegal). The driver plays both command source and
// function-unit bank, and keeps the expected per-cycle outputs up to date;
// a negedge process compares the DUT against them every cycle.
// Honours ALU_DISPATCH_TIMEOUT_EN when it is defined for the build.
module tb_alu_dispatch;
  localparam int NUM_OPS = 6;
  localparam int OP_W    = 3;
  localparam int TIMEOUT = 15;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [OP_W-1:0]       cmd_op;
  logic [7:0]            cmd_a, cmd_b;
  logic [7:0]            unit_a, unit_b;
  logic [NUM_OPS-1:0]    unit_start;
  logic [NUM_OPS-1:0]    unit_done;
  logic [16*NUM_OPS-1:0] unit_res;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [15:0]           rsp_res;
  logic                  rsp_zero, rsp_neg, rsp_err;

  always #5 clk = ~clk;

  alu_dispatch #(.NUM_OPS(NUM_OPS), .OP_W(OP_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
    .unit_a_o(unit_a), .unit_b_o(unit_b),
    .unit_start_o(unit_start), .unit_done_i(unit_done), .unit_res_i(unit_res),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_res_o(rsp_res), .rsp_zero_o(rsp_zero), .rsp_neg_o(rsp_neg), .rsp_err_o(rsp_err)
  );

  // Expected outputs after the most recent rising edge.
  logic               expReady, expValid, expRspKnown;
  logic [NUM_OPS-1:0] expStart;
  logic [7:0]         expA, expB;
  logic [15:0]        expRes;
  logic               expZero, expNeg, expErr;

  int nChecks = 0;
  int nPass   = 0;

  // Response seen by the driver when rsp_valid first rose.
  logic [15:0] gotRes;
  logic        gotZero, gotNeg, gotErr;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
  endtask

  always @(negedge clk) begin
    checkOutput("cmd_ready", 16'(cmd_ready), 16'(expReady));
    checkOutput("unit_start", 16'(unit_start), 16'(expStart));
    checkOutput("unit_a", 16'(unit_a), 16'(expA));
    checkOutput("unit_b", 16'(unit_b), 16'(expB));
    checkOutput("rsp_valid", 16'(rsp_valid), 16'(expValid));
    if (expRspKnown) begin
      checkOutput("rsp_res", rsp_res, expRes);
      checkOutput("rsp_zero", 16'(rsp_zero), 16'(expZero));
      checkOutput("rsp_neg", 16'(rsp_neg), 16'(expNeg));
      checkOutput("rsp_err", 16'(rsp_err), 16'(expErr));
    end
  end

  // What each attached unit computes.
  function automatic logic [15:0] opResult(input int op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      0:       return {8'h00, a & b};
      1:       return {8'h00, a | b};
      2:       return {8'h00, a} + {8'h00, b};
      3:       return {8'h00, a} * {8'h00, b};
      4:       return {8'h00, a ^ b};
      default: return {8'h00, a} - {8'h00, b};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleUnits();
    unit_done = '0;
    for (int i = 0; i < NUM_OPS; i++) unit_res[16*i +: 16] = 16'($urandom);
  endtask

  // Commands offered while busy must never be consumed.
  task automatic driveJunk(input int pct);
    if ($urandom_range(99) < pct) begin
      cmd_valid = 1'b1;
      cmd_op    = OP_W'($urandom);
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);
    end else begin
      cmd_valid = 1'b0;
    end
  endtask

  // One full command. lat = cycles from start being sampled until done is
  // visible minus one (lat=1: done visible after accept edge + 2).
  // rstAt != 0 asserts reset during the WAIT cycle with that index.
  task automatic applyStimulus(input int op, input logic [7:0] a, input logic [7:0] b,
                               input int lat, input int holdCyc, input int junkPct,
                               input int strayPct, input int rstAt);
    bit          legal;
    int          r;
    int          other;
    int          lateUnit;
    logic [15:0] res;
    legal    = (op < NUM_OPS);
    lateUnit = legal ? op : 0;
    res      = opResult(op, a, b);

    cmd_valid = 1'b1;
    cmd_op    = OP_W'(op);
    cmd_a     = a;
    cmd_b     = b;
    idleUnits();
    tick();
    expReady = 1'b0;
    expStart = legal ? (NUM_OPS'(1) << op) : '0;
    expA     = a;
    expB     = b;
    driveJunk(junkPct);
    idleUnits();
    tick();
    expStart = '0;

    if (!legal) begin
      expValid = 1'b1; expRspKnown = 1'b1;
      expRes = 16'h0000; expZero = 1'b1; expNeg = 1'b0; expErr = 1'b1;
    end else begin
      r = 1;
      while (!expValid) begin
        idleUnits();
        driveJunk(junkPct);
        if (r == 1 + lat) begin
          unit_done[op] = 1'b1;
          unit_res[16*op +: 16] = res;
        end
        if ($urandom_range(99) < strayPct) begin
          other = (op + 1 + int'($urandom_range(NUM_OPS - 2))) % NUM_OPS;
          unit_done[other] = 1'b1;
          unit_res[16*other +: 16] = 16'hFFFF;
        end
        if (rstAt != 0 && r == rstAt) begin
          #2;
          rst_n = 1'b0;
          #1;
          checkOutput("rst_unit_start", 16'(unit_start), 16'h0000);
          checkOutput("rst_rsp_valid", 16'(rsp_valid), 16'h0000);
          checkOutput("rst_cmd_ready", 16'(cmd_ready), 16'h0001);
          expReady = 1'b1; expStart = '0; expA = 8'h00; expB = 8'h00; expValid = 1'b0;
          expRspKnown = 1'b1; expRes = 16'h0000; expZero = 1'b0; expNeg = 1'b0; expErr = 1'b0;
          cmd_valid = 1'b0;
          idleUnits();
          tick();
          rst_n = 1'b1;
          unit_done[op] = 1'b1;
          unit_res[16*op +: 16] = res;
          tick();
          idleUnits();
          tick();
          return;
        end
        tick();
        r++;
        if (r == 2 + lat) begin
          expValid = 1'b1; expRspKnown = 1'b1;
          expRes = res; expZero = (res == 16'h0000); expNeg = res[15]; expErr = 1'b0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
        end else if (r == 1 + TIMEOUT) begin
          expValid = 1'b1; expRspKnown = 1'b1;
          expRes = 16'h0000; expZero = 1'b1; expNeg = 1'b0; expErr = 1'b1;
`endif
        end
        if (r > 400 && !expValid) begin
          nChecks++;
          $display("[TB] FAIL wait_bound: got %0d wait cycles, expected at most 400", r);
          expValid = 1'b1;
        end
      end
    end

    gotRes = rsp_res; gotZero = rsp_zero; gotNeg = rsp_neg; gotErr = rsp_err;

    for (int h = 0; h < holdCyc; h++) begin
      idleUnits();
      driveJunk(junkPct);
      rsp_ready = 1'b0;
      if ($urandom_range(99) < strayPct) unit_done[lateUnit] = 1'b1;
      tick();
    end
    idleUnits();
    driveJunk(junkPct);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    expValid = 1'b0; expReady = 1'b1; expRspKnown = 1'b0;
    idleUnits();
    if ($urandom_range(99) < strayPct) begin
      unit_done[lateUnit] = 1'b1;
      tick();
      idleUnits();
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 2 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int op, lat, rstAt;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = 8'h00; cmd_b = 8'h00;
    rsp_ready = 1'b0; unit_done = '0; unit_res = '0;
    expReady = 1'b1; expStart = '0; expA = 8'h00; expB = 8'h00; expValid = 1'b0;
    expRspKnown = 1'b1; expRes = 16'h0000; expZero = 1'b0; expNeg = 1'b0; expErr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    applyStimulus(0, 8'hF0, 8'h3C, 1, 0, 0, 0, 0);
    checkOutput("and_f0_3c_res", gotRes, 16'h0030);
    checkOutput("and_f0_3c_zero", 16'(gotZero), 16'h0000);
    checkOutput("and_f0_3c_err", 16'(gotErr), 16'h0000);

    applyStimulus(0, 8'h0F, 8'hF0, 1, 5, 100, 0, 0);
    checkOutput("and_0f_f0_res", gotRes, 16'h0000);
    checkOutput("and_0f_f0_zero", 16'(gotZero), 16'h0001);

    applyStimulus(7, 8'h55, 8'hAA, 1, 1, 0, 0, 0);
    checkOutput("illegal_res", gotRes, 16'h0000);
    checkOutput("illegal_zero", 16'(gotZero), 16'h0001);
    checkOutput("illegal_err", 16'(gotErr), 16'h0001);

    applyStimulus(2, 8'h80, 8'h90, 4, 1, 50, 100, 0);
    checkOutput("add_stray_res", gotRes, 16'h0110);

    applyStimulus(5, 8'h10, 8'h20, 2, 0, 0, 0, 0);
    checkOutput("sub_neg_res", gotRes, 16'hFFF0);
    checkOutput("sub_neg_flag", 16'(gotNeg), 16'h0001);

    applyStimulus(3, 8'h77, 8'h66, 10, 0, 0, 0, 3);
    applyStimulus(3, 8'h12, 8'h34, 1, 0, 0, 0, 0);
    checkOutput("mul_after_rst_res", gotRes, 16'h03A8);

`ifdef ALU_DISPATCH_TIMEOUT_EN
    applyStimulus(3, 8'h11, 8'h22, 100000, 2, 0, 100, 0);
    checkOutput("timeout_err", 16'(gotErr), 16'h0001);
    checkOutput("timeout_res", gotRes, 16'h0000);
    applyStimulus(1, 8'hA0, 8'h05, 14, 0, 0, 0, 0);
    checkOutput("tie_done_wins_res", gotRes, 16'h00A5);
    checkOutput("tie_done_wins_err", 16'(gotErr), 16'h0000);
`endif

    for (int n = 0; n < 150; n++) begin
      op  = int'($urandom_range(7));
      lat = ($urandom_range(9) == 0) ? int'($urandom_range(20, 6)) : int'($urandom_range(4, 1));
`ifdef ALU_DISPATCH_TIMEOUT_EN
      if ($urandom_range(5) == 0) lat = int'($urandom_range(TIMEOUT + 2, TIMEOUT - 2));
`endif
      rstAt = ($urandom_range(24) == 0 && op < NUM_OPS) ?
              int'($urandom_range((lat > 10) ? 10 : lat, 1)) : 0;
      applyStimulus(op, 8'($urandom), 8'($urandom), lat, int'($urandom_range(3)), 40, 30, rstAt);
    end

    tick();
    tick();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
